// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX arbiter slice.
package uart_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam logic [3:0]  TAG_PREFIX = 4'hA;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TAG    = 2'd1,
        STREAM = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the serializer valid/ready link; master is the arbiter side.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_SRC = 4
);
    import uart_pkg::*;

    logic [NUM_SRC*BYTE_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_last;
    logic [NUM_SRC-1:0]        src_ready;
    logic [BYTE_W-1:0]         tx_data;
    logic                      tx_valid;
    logic                      tx_ready;

    modport master (
        input  src_data, src_valid, src_last, tx_ready,
        output src_ready, tx_data, tx_valid
    );

    modport slave (
        output src_data, src_valid, src_last, tx_ready,
        input  src_ready, tx_data, tx_valid
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping.
module uart_rr_pick #(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]         req,
    input  logic [$clog2(NUM_SRC)-1:0] rr_ptr,
    output logic                       pick_valid,
    output logic [$clog2(NUM_SRC)-1:0] pick_idx
);
    localparam int unsigned PW = $clog2(NUM_SRC);

    int unsigned idx;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!pick_valid && req[PW'(idx)]) begin
                pick_valid = 1'b1;
                pick_idx   = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding one uart_tx serializer.
// Define UART_TX_ARB_TAG_EN to prefix each grant with a {TAG_PREFIX, source id} byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_SRC       = 4,
    parameter int unsigned MAX_PKT_BYTES = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_tx_arbiter_if.master          bus,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy
);
    localparam int unsigned PW = $clog2(NUM_SRC);
    localparam int unsigned CW = $clog2(MAX_PKT_BYTES + 1);

    if (NUM_SRC < 2) begin : g_bad_num_src
        $error("uart_tx_arbiter: NUM_SRC must be >= 2");
    end
    if (MAX_PKT_BYTES < 1) begin : g_bad_max_pkt
        $error("uart_tx_arbiter: MAX_PKT_BYTES must be >= 1");
    end
`ifdef UART_TX_ARB_TAG_EN
    if (NUM_SRC > 16) begin : g_bad_tag_width
        $error("uart_tx_arbiter: tag byte holds at most 16 source ids");
    end
`endif

    arb_state_t        state, state_d;
    logic [PW-1:0]     rr_ptr, rr_ptr_d;
    logic [PW-1:0]     grant_d;
    logic [CW-1:0]     byte_cnt, byte_cnt_d;
    logic              pick_valid;
    logic [PW-1:0]     pick_idx;
    logic [BYTE_W-1:0] src_bytes [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_bytes[i] = bus.src_data[i*BYTE_W +: BYTE_W];
    end

    uart_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req        (bus.src_valid),
        .rr_ptr     (rr_ptr),
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx)
    );

    // State and grant bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            byte_cnt <= '0;
        end else begin
            state    <= state_d;
            rr_ptr   <= rr_ptr_d;
            grant_id <= grant_d;
            byte_cnt <= byte_cnt_d;
        end
    end

    // Next state and the combinational pass-through data path
    always_comb begin
        state_d       = state;
        rr_ptr_d      = rr_ptr;
        grant_d       = grant_id;
        byte_cnt_d    = byte_cnt;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = src_bytes[grant_id];
        bus.src_ready = '0;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_d    = pick_idx;
                    byte_cnt_d = '0;
`ifdef UART_TX_ARB_TAG_EN
                    state_d    = TAG;
`else
                    state_d    = STREAM;
`endif
                end
            end
`ifdef UART_TX_ARB_TAG_EN
            TAG: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = {TAG_PREFIX, 4'(grant_id)};
                if (bus.tx_ready) state_d = STREAM;
            end
`endif
            STREAM: begin
                bus.tx_valid            = bus.src_valid[grant_id];
                bus.src_ready[grant_id] = bus.tx_ready;
                if (bus.src_valid[grant_id] && bus.tx_ready) begin
                    // last and the byte cap landing together is one release
                    if (bus.src_last[grant_id] || (byte_cnt == CW'(MAX_PKT_BYTES - 1))) begin
                        state_d    = IDLE;
                        byte_cnt_d = '0;
                        rr_ptr_d   = (grant_id == PW'(NUM_SRC - 1)) ? '0 : grant_id + PW'(1);
                    end else begin
                        byte_cnt_d = byte_cnt + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle vector table plus scripted multi-cycle sequences.
module tb_uart_tx_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] grant_id;
    logic       busy;

    uart_tx_arbiter_if #(.NUM_SRC(4)) bus ();

    uart_tx_arbiter #(.NUM_SRC(4), .MAX_PKT_BYTES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.master),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        rdy;
        logic        e_valid;
        logic [7:0]  e_data;
        logic [3:0]  e_ready;
        logic [1:0]  e_gid;
        logic        e_busy;
        logic [1:0]  e_rr;
    } vec_t;

    vec_t vecs[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int base    = 0;

    logic       rdy;
    logic       rst_v;
    logic [3:0] pop;
    logic [8:0] q [4][$];
    logic [7:0] log_data[$];
    logic [1:0] log_gid[$];
    int         log_cyc[$];

    function automatic vec_t mkv(input logic r, input logic [3:0] v, input logic [3:0] l,
                                 input logic [31:0] d, input logic rd, input logic ev,
                                 input logic [7:0] ed, input logic [3:0] er, input logic [1:0] eg,
                                 input logic eb, input logic [1:0] err);
        vec_t t;
        t.rst = r; t.valid = v; t.last = l; t.data = d; t.rdy = rd;
        t.e_valid = ev; t.e_data = ed; t.e_ready = er; t.e_gid = eg; t.e_busy = eb; t.e_rr = err;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of the queue-driven source model; outputs are logged at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (pop[i] && q[i].size() > 0) q[i].delete(0);
            if (q[i].size() > 0) begin
                bus.src_valid[i]       = 1'b1;
                bus.src_last[i]        = q[i][0][8];
                bus.src_data[i*8 +: 8] = q[i][0][7:0];
            end else begin
                bus.src_valid[i]       = 1'b0;
                bus.src_last[i]        = 1'b0;
                bus.src_data[i*8 +: 8] = 8'h00;
            end
        end
        bus.tx_ready = rdy;
        rst          = rst_v;
        @(negedge clk);
        cyc++;
        pop = '0;
        if (bus.tx_valid && bus.tx_ready) begin
            log_data.push_back(bus.tx_data);
            log_gid.push_back(grant_id);
            log_cyc.push_back(cyc - base - 1);
        end
        for (int i = 0; i < 4; i++)
            if (bus.src_ready[i] && bus.src_valid[i]) pop[i] = 1'b1;
    endtask

    task automatic start_seq();
        base = cyc;
        log_data.delete();
        log_gid.delete();
        log_cyc.delete();
    endtask

    task automatic chk_tx(input string name, input int idx, input logic [7:0] d,
                          input logic [1:0] g, input int c);
        if (idx >= log_data.size()) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: transfer %0d missing, got %0d transfers, expected data 0x%0h",
                     name, idx, log_data.size(), d);
        end else begin
            chk($sformatf("%s[%0d].data", name, idx), 32'(log_data[idx]), 32'(d));
            chk($sformatf("%s[%0d].gid", name, idx), 32'(log_gid[idx]), 32'(g));
            chk($sformatf("%s[%0d].cycle", name, idx), 32'(log_cyc[idx]), 32'(c));
        end
    endtask

    initial begin
        rst = 1'b1;
        rst_v = 1'b1;
        rdy = 1'b1;
        pop = '0;
        bus.src_data  = '0;
        bus.src_valid = '0;
        bus.src_last  = '0;
        bus.tx_ready  = 1'b1;
        tick();
        tick();

`ifdef UART_TX_ARB_TAG_EN
        // Tag byte precedes the payload and does not count toward the byte cap
        rst_v = 1'b0;
        start_seq();
        q[2].push_back({1'b1, 8'h41});
        tick();
        chk("tag.idle_busy", 32'(busy), 32'd0);
        tick();
        chk("tag.tx_valid", 32'(bus.tx_valid), 32'd1);
        chk("tag.tx_data", 32'(bus.tx_data), 32'hA2);
        chk("tag.src_ready", 32'(bus.src_ready), 32'h0);
        chk("tag.busy", 32'(busy), 32'd1);
        tick();
        chk("tag.byte_cnt", 32'(dut.byte_cnt), 32'd0);
        chk("tag.payload", 32'(bus.tx_data), 32'h41);
        chk("tag.payload_ready", 32'(bus.src_ready), 32'h4);
        tick();
        chk("tag.busy_after", 32'(busy), 32'd0);
        chk("tag.rr_ptr", 32'(dut.rr_ptr), 32'd3);
        chk("tag.count", 32'(log_data.size()), 32'd2);
        chk_tx("tag", 0, 8'hA2, 2'd2, 1);
        chk_tx("tag", 1, 8'h41, 2'd2, 2);
`else
        // Reset state, round robin across four 1-byte requesters, then single-source packet
        vecs.push_back(mkv(1, 4'h0, 4'h0, 32'h0,        1, 0, 8'h00, 4'h0, 0, 0, 0));
        vecs.push_back(mkv(0, 4'hF, 4'hF, 32'hB3B2B1B0, 1, 0, 8'hB0, 4'h0, 0, 0, 0));
        vecs.push_back(mkv(0, 4'hF, 4'hF, 32'hB3B2B1B0, 1, 1, 8'hB0, 4'h1, 0, 1, 0));
        vecs.push_back(mkv(0, 4'hF, 4'hF, 32'hB3B2B1B0, 1, 0, 8'hB0, 4'h0, 0, 0, 1));
        vecs.push_back(mkv(0, 4'hF, 4'hF, 32'hB3B2B1B0, 1, 1, 8'hB1, 4'h2, 1, 1, 1));
        vecs.push_back(mkv(0, 4'hF, 4'hF, 32'hB3B2B1B0, 1, 0, 8'hB1, 4'h0, 1, 0, 2));
        vecs.push_back(mkv(0, 4'hF, 4'hF, 32'hB3B2B1B0, 1, 1, 8'hB2, 4'h4, 2, 1, 2));
        vecs.push_back(mkv(0, 4'hF, 4'hF, 32'hB3B2B1B0, 1, 0, 8'hB2, 4'h0, 2, 0, 3));
        vecs.push_back(mkv(0, 4'hF, 4'hF, 32'hB3B2B1B0, 1, 1, 8'hB3, 4'h8, 3, 1, 3));
        vecs.push_back(mkv(0, 4'hF, 4'hF, 32'hB3B2B1B0, 1, 0, 8'hB3, 4'h0, 3, 0, 0));
        vecs.push_back(mkv(0, 4'hF, 4'hF, 32'hB3B2B1B0, 1, 1, 8'hB0, 4'h1, 0, 1, 0));
        vecs.push_back(mkv(1, 4'h0, 4'h0, 32'h0,        1, 0, 8'h00, 4'h0, 0, 0, 1));
        vecs.push_back(mkv(0, 4'h4, 4'h0, 32'h00110000, 1, 0, 8'h00, 4'h0, 0, 0, 0));
        vecs.push_back(mkv(0, 4'h4, 4'h0, 32'h00110000, 1, 1, 8'h11, 4'h4, 2, 1, 0));
        vecs.push_back(mkv(0, 4'h4, 4'h0, 32'h00220000, 1, 1, 8'h22, 4'h4, 2, 1, 0));
        vecs.push_back(mkv(0, 4'h4, 4'h4, 32'h00330000, 1, 1, 8'h33, 4'h4, 2, 1, 0));
        vecs.push_back(mkv(0, 4'h0, 4'h0, 32'h0,        1, 0, 8'h00, 4'h0, 2, 0, 3));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst           = vecs[i].rst;
            bus.src_valid = vecs[i].valid;
            bus.src_last  = vecs[i].last;
            bus.src_data  = vecs[i].data;
            bus.tx_ready  = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d.tx_valid", i), 32'(bus.tx_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid)
                chk($sformatf("v%0d.tx_data", i), 32'(bus.tx_data), 32'(vecs[i].e_data));
            chk($sformatf("v%0d.src_ready", i), 32'(bus.src_ready), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d.grant_id", i), 32'(grant_id), 32'(vecs[i].e_gid));
            chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d.rr_ptr", i), 32'(dut.rr_ptr), 32'(vecs[i].e_rr));
        end
        chk("reset.tx_data", 32'(vecs[0].e_data), 32'h00);

        // Byte cap of 4: src 1 alone streams 10 bytes without last -> 4/4/2 chunks
        rst_v = 1'b1;
        tick();
        rst_v = 1'b0;
        start_seq();
        for (int k = 0; k < 10; k++) q[1].push_back({1'b0, 8'(k + 1)});
        for (int k = 0; k < 14; k++) tick();
        chk("cap.count", 32'(log_data.size()), 32'd10);
        begin
            int cap_cyc[10] = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12};
            for (int k = 0; k < 10; k++) chk_tx("cap", k, 8'(k + 1), 2'd1, cap_cyc[k]);
        end
        chk("cap.hold_busy", 32'(busy), 32'd1);
        chk("cap.hold_gid", 32'(grant_id), 32'd1);
        chk("cap.hold_valid", 32'(bus.tx_valid), 32'd0);

        // Cap hit with others waiting: src 2 and src 0 are served before src 1 returns
        start_seq();
        q[1].push_back({1'b0, 8'h0B});
        q[1].push_back({1'b0, 8'h0C});
        q[1].push_back({1'b1, 8'h0D});
        q[0].push_back({1'b1, 8'hC0});
        q[2].push_back({1'b1, 8'hC2});
        for (int k = 0; k < 9; k++) tick();
        chk("fair.count", 32'(log_data.size()), 32'd5);
        chk_tx("fair", 0, 8'h0B, 2'd1, 0);
        chk_tx("fair", 1, 8'h0C, 2'd1, 1);
        chk_tx("fair", 2, 8'hC2, 2'd2, 3);
        chk_tx("fair", 3, 8'hC0, 2'd0, 5);
        chk_tx("fair", 4, 8'h0D, 2'd1, 7);
        chk("fair.rr_ptr", 32'(dut.rr_ptr), 32'd2);

        // Reset during src 3's second byte abandons the packet and rewinds rr_ptr
        start_seq();
        q[3].push_back({1'b0, 8'h31});
        q[3].push_back({1'b0, 8'h32});
        q[3].push_back({1'b1, 8'h33});
        tick();
        tick();
        rst_v = 1'b1;
        tick();
        rst_v = 1'b0;
        q[3].delete();
        pop = '0;
        q[1].push_back({1'b1, 8'h71});
        q[3].push_back({1'b1, 8'h3F});
        tick();
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.grant_id", 32'(grant_id), 32'd0);
        chk("rst.rr_ptr", 32'(dut.rr_ptr), 32'd0);
        for (int k = 0; k < 4; k++) tick();
        chk("rst.count", 32'(log_data.size()), 32'd4);
        chk_tx("rst", 0, 8'h31, 2'd3, 1);
        chk_tx("rst", 1, 8'h32, 2'd3, 2);
        chk_tx("rst", 2, 8'h71, 2'd1, 4);
        chk_tx("rst", 3, 8'h3F, 2'd3, 6);

        // Backpressure: tx_ready low for 20 cycles while 0x5A is offered
        start_seq();
        rdy = 1'b0;
        q[3].push_back({1'b0, 8'h5A});
        q[3].push_back({1'b1, 8'h5B});
        tick();
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("bp%0d.tx_valid", k), 32'(bus.tx_valid), 32'd1);
            chk($sformatf("bp%0d.tx_data", k), 32'(bus.tx_data), 32'h5A);
            chk($sformatf("bp%0d.src_ready", k), 32'(bus.src_ready), 32'h0);
        end
        rdy = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("bp.count", 32'(log_data.size()), 32'd2);
        chk_tx("bp", 0, 8'h5A, 2'd3, 21);
        chk_tx("bp", 1, 8'h5B, 2'd3, 22);
        chk("bp.busy_after", 32'(busy), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
